// File: rtl/elevator_defs_pkg.sv
// Shared elevator definitions: direction codes and default floor geometry,
// used by the floor-call register, the floor FSM and the direction matrix logic.
package elevator_defs_pkg;

    localparam int N_FLOORS_DEF = 3;
    localparam int FLOOR_W_DEF  = 2;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Single-bit call button conditioner: 2-flop synchroniser, a previous-value
// flop and a rising-edge pulse that lasts exactly one clock.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A held button produces one pulse; it must drop low before it can fire again.
    assign rise = s2 & ~s3;

endmodule

// File: rtl/floor_call_register.sv
// Floor-call register: latches one pending request per floor from conditioned
// buttons, clears it on door-open service, and schedules the next target floor.
module floor_call_register
    import elevator_defs_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FLOOR_W  = FLOOR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                door_open,
    input  logic                alarm,
    output logic [N_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]  target,
    output logic                target_valid,
    output logic [1:0]          dir,
    output logic                served
);

    logic [N_FLOORS-1:0] rise;

    for (genvar g = 0; g < N_FLOORS; g++) begin : g_sync
        btn_edge_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[g]),
            .rise  (rise[g])
        );
    end

    dir_t                state;
    dir_t                dir_next;
    int                  cur_int;
    logic                floor_ok;
    logic [N_FLOORS-1:0] set_mask;
    logic [N_FLOORS-1:0] clr_mask;
    logic [N_FLOORS-1:0] req_next;
    logic                served_next;
    logic [N_FLOORS-1:0] above;
    logic [N_FLOORS-1:0] below;
    logic                any_above;
    logic                any_below;
    logic                at_here;
    logic [FLOOR_W-1:0]  up_tgt;
    logic [FLOOR_W-1:0]  dn_tgt;
    logic [FLOOR_W-1:0]  tgt_next;

    // The state register is the dir output, so the FSM state is always observable.
    assign dir = state;

    always_comb begin
        cur_int     = int'(cur_floor);
        floor_ok    = (cur_int < N_FLOORS);
        set_mask    = rise & {N_FLOORS{~alarm}};
        clr_mask    = '0;
        above       = '0;
        below       = '0;
        up_tgt      = '0;
        dn_tgt      = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            clr_mask[i] = door_open && (cur_int == i);
            above[i]    = req[i] && (i > cur_int);
            below[i]    = req[i] && (i < cur_int);
        end
        // Downward scan leaves the lowest hit; upward scan leaves the highest.
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (above[i]) up_tgt = FLOOR_W'(i);
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (below[i]) dn_tgt = FLOOR_W'(i);
        end
        any_above   = |above;
        any_below   = |below;
        at_here     = |(req & ~above & ~below);

        // Clear wins over a same-cycle set on the same bit.
        req_next    = (req | set_mask) & ~clr_mask;
        served_next = |((req | set_mask) & clr_mask);

        dir_next = state;
        unique case (state)
            DIR_UP:   if (!any_above) dir_next = any_below ? DIR_DOWN : DIR_IDLE;
            DIR_DOWN: if (!any_below) dir_next = any_above ? DIR_UP : DIR_IDLE;
            default:  begin
                if (any_above)      dir_next = DIR_UP;
                else if (any_below) dir_next = DIR_DOWN;
                else                dir_next = DIR_IDLE;
            end
        endcase
        // Only the current floor pending: keep heading, just point at this floor.
        if (!any_above && !any_below && at_here) dir_next = state;

        tgt_next = target;
        if (dir_next == DIR_UP && any_above)          tgt_next = up_tgt;
        else if (dir_next == DIR_DOWN && any_below)   tgt_next = dn_tgt;
        else if (at_here)                             tgt_next = cur_floor;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req          <= '0;
            served       <= 1'b0;
            state        <= DIR_IDLE;
            target       <= '0;
            target_valid <= 1'b0;
        end else begin
            req    <= req_next;
            served <= served_next;
            if (!alarm && floor_ok) begin
                state        <= dir_next;
                target       <= tgt_next;
                target_valid <= |req;
            end
        end
    end

endmodule

// File: tb/tb_floor_call_register.sv
// Directed bench for floor_call_register: one task per scenario, each with its
// own expected values worked out by hand from the intended behaviour.
module tb_floor_call_register;

    localparam int N = 3;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn;
    logic [W-1:0] cur_floor;
    logic         door_open;
    logic         alarm;
    logic [N-1:0] req;
    logic [W-1:0] target;
    logic         target_valid;
    logic [1:0]   dir;
    logic         served;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    floor_call_register #(.N_FLOORS(N), .FLOOR_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .cur_floor    (cur_floor),
        .door_open    (door_open),
        .alarm        (alarm),
        .req          (req),
        .target       (target),
        .target_valid (target_valid),
        .dir          (dir),
        .served       (served)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; btn = 3'b111; cur_floor = 2'd0; door_open = 1'b0; alarm = 1'b0;
        step(2);
        n_cmp++;
        if ({req, dir, target, target_valid, served} !== 9'b000_00_00_0_0) begin
            n_bad++;
            $display("FAIL reset_state: req/dir/target/tv/served got %b expected %b",
                     {req, dir, target, target_valid, served}, 9'b000_00_00_0_0);
        end
        btn = 3'b000;
        step(1);
        reset = 1'b1;
        step(4);
        n_cmp++;
        if (req !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release_req: got %b expected 000", req);
        end
    endtask

    task automatic test_latency;
        btn = 3'b100;
        step(2);
        n_cmp++;
        if (req !== 3'b000) begin
            n_bad++;
            $display("FAIL latency_early: req got %b expected 000", req);
        end
        step(1);
        n_cmp++;
        if ({req, dir} !== 5'b100_00) begin
            n_bad++;
            $display("FAIL latency_req: req/dir got %b expected %b", {req, dir}, 5'b100_00);
        end
        step(1);
        btn = 3'b000;
        n_cmp++;
        if ({dir, target, target_valid} !== 5'b01_10_1) begin
            n_bad++;
            $display("FAIL latency_target: dir/target/tv got %b expected %b",
                     {dir, target, target_valid}, 5'b01_10_1);
        end
    endtask

    task automatic test_scan_order;
        cur_floor = 2'd1;
        step(1);
        n_cmp++;
        if ({dir, target} !== 4'b01_10) begin
            n_bad++;
            $display("FAIL scan_floor1: dir/target got %b expected %b", {dir, target}, 4'b01_10);
        end
        btn = 3'b001;
        step(3);
        btn = 3'b000;
        n_cmp++;
        if (req !== 3'b101) begin
            n_bad++;
            $display("FAIL scan_req: got %b expected 101", req);
        end
        step(1);
        n_cmp++;
        if ({dir, target} !== 4'b01_10) begin
            n_bad++;
            $display("FAIL scan_up_lowest: dir/target got %b expected %b", {dir, target}, 4'b01_10);
        end
        cur_floor = 2'd2; door_open = 1'b1;
        step(1);
        n_cmp++;
        if ({req, served} !== 4'b001_1) begin
            n_bad++;
            $display("FAIL scan_clear: req/served got %b expected %b", {req, served}, 4'b001_1);
        end
        step(1);
        door_open = 1'b0;
        n_cmp++;
        if ({served, dir, target, target_valid} !== 6'b0_10_00_1) begin
            n_bad++;
            $display("FAIL scan_turn_down: served/dir/target/tv got %b expected %b",
                     {served, dir, target, target_valid}, 6'b0_10_00_1);
        end
    endtask

    task automatic test_simultaneous;
        cur_floor = 2'd1; btn = 3'b010;
        step(2);
        door_open = 1'b1;
        step(1);
        n_cmp++;
        if ({req, served} !== 4'b001_1) begin
            n_bad++;
            $display("FAIL simul_clear_wins: req/served got %b expected %b", {req, served}, 4'b001_1);
        end
        door_open = 1'b0;
        step(1);
        btn = 3'b000;
        n_cmp++;
        if ({req, served, dir, target} !== 8'b001_0_10_00) begin
            n_bad++;
            $display("FAIL simul_after: req/served/dir/target got %b expected %b",
                     {req, served, dir, target}, 8'b001_0_10_00);
        end
    endtask

    task automatic test_alarm;
        alarm = 1'b1; cur_floor = 2'd0; door_open = 1'b1; btn = 3'b001;
        step(1);
        n_cmp++;
        if ({req, served} !== 4'b000_1) begin
            n_bad++;
            $display("FAIL alarm_clear: req/served got %b expected %b", {req, served}, 4'b000_1);
        end
        door_open = 1'b0;
        step(3);
        n_cmp++;
        if ({req, dir, target, target_valid} !== 8'b000_10_00_1) begin
            n_bad++;
            $display("FAIL alarm_freeze: req/dir/target/tv got %b expected %b",
                     {req, dir, target, target_valid}, 8'b000_10_00_1);
        end
        alarm = 1'b0;
        step(3);
        btn = 3'b000;
        n_cmp++;
        if ({req, dir, target_valid} !== 6'b000_00_0) begin
            n_bad++;
            $display("FAIL alarm_no_late_set: req/dir/tv got %b expected %b",
                     {req, dir, target_valid}, 6'b000_00_0);
        end
    endtask

    task automatic test_held_button;
        cur_floor = 2'd0; btn = 3'b010;
        step(3);
        n_cmp++;
        if (req !== 3'b010) begin
            n_bad++;
            $display("FAIL held_set: req got %b expected 010", req);
        end
        step(1);
        n_cmp++;
        if ({dir, target} !== 4'b01_01) begin
            n_bad++;
            $display("FAIL held_target: dir/target got %b expected %b", {dir, target}, 4'b01_01);
        end
        cur_floor = 2'd1; door_open = 1'b1;
        step(1);
        n_cmp++;
        if ({req, served} !== 4'b000_1) begin
            n_bad++;
            $display("FAIL held_clear: req/served got %b expected %b", {req, served}, 4'b000_1);
        end
        door_open = 1'b0;
        step(15);
        btn = 3'b000;
        n_cmp++;
        if ({req, served, dir, target_valid} !== 7'b000_0_00_0) begin
            n_bad++;
            $display("FAIL held_no_rearm: req/served/dir/tv got %b expected %b",
                     {req, served, dir, target_valid}, 7'b000_0_00_0);
        end
    endtask

    task automatic test_out_of_range;
        btn = 3'b100;
        step(3);
        btn = 3'b000;
        step(1);
        n_cmp++;
        if ({req, dir, target, target_valid} !== 8'b100_01_10_1) begin
            n_bad++;
            $display("FAIL oor_setup: req/dir/target/tv got %b expected %b",
                     {req, dir, target, target_valid}, 8'b100_01_10_1);
        end
        cur_floor = 2'd3; door_open = 1'b1;
        step(3);
        n_cmp++;
        if ({req, served, dir, target} !== 8'b100_0_01_10) begin
            n_bad++;
            $display("FAIL oor_hold: req/served/dir/target got %b expected %b",
                     {req, served, dir, target}, 8'b100_0_01_10);
        end
        cur_floor = 2'd2;
        step(1);
        n_cmp++;
        if ({req, served} !== 4'b000_1) begin
            n_bad++;
            $display("FAIL oor_back_in_range: req/served got %b expected %b", {req, served}, 4'b000_1);
        end
        door_open = 1'b0;
        step(2);
        n_cmp++;
        if ({dir, target, target_valid} !== 5'b00_10_0) begin
            n_bad++;
            $display("FAIL oor_idle: dir/target/tv got %b expected %b",
                     {dir, target, target_valid}, 5'b00_10_0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan_order();
        test_simultaneous();
        test_alarm();
        test_held_button();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
